bnn_vote_accumulator: RTL and testbench



---
 rtl/bnn_pkg.sv | 24 ++
 rtl/bnn_vote_counter_bank.sv | 53 +++++
 rtl/bnn_vote_accumulator.sv | 195 +++++++++++++++++++
 tb/tb_bnn_vote_accumulator.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bnn_pkg.sv
// Shared constants and types for the 8-8-4 BNN core and its vote accumulator.
// Contents: layer sizes, vote accumulator defaults, vote_state_t.
package bnn_pkg;

   // Layer sizes of the BNN core (input, hidden, output neurons).
   localparam int unsigned L0_SIZE = 8;
   localparam int unsigned L1_SIZE = 8;
   localparam int unsigned L2_SIZE = 4;

   // Vote accumulator defaults; one class per output neuron.
   localparam int unsigned NUM_CLASSES  = L2_SIZE;
   localparam int unsigned CLASS_W      = 2;
   localparam int unsigned CNT_W        = 5;
   localparam int unsigned VOTE_WINDOW  = 16;
   localparam int unsigned SAMPLE_W     = 8;   // holds WINDOW up to 255

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      SCAN  = 2'd2,
      HOLD  = 2'd3
   } vote_state_t;

endpackage

// File: rtl/bnn_vote_counter_bank.sv
// Per-class fire counters with synchronous clear, load and increment, plus a
// read mux used by the argmax scan.
// Ports: clk, reset (async, active-high), clr_i, ld_i, inc_i, bits_i (one bit
// per class), rd_idx_i (class to read), rd_cnt_o (count of that class).
module bnn_vote_counter_bank #(
   parameter int unsigned NUM_CLASSES = 4,
   parameter int unsigned CNT_W       = 5,
   parameter int unsigned CLASS_W     = 2,
   parameter int unsigned WINDOW      = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   clr_i,
   input  logic                   ld_i,
   input  logic                   inc_i,
   input  logic [NUM_CLASSES-1:0] bits_i,
   input  logic [CLASS_W-1:0]     rd_idx_i,
   output logic [CNT_W-1:0]       rd_cnt_o
);

   logic [CNT_W-1:0] cnt_q [NUM_CLASSES];
   logic [CNT_W-1:0] cnt_d [NUM_CLASSES];

   // Priority: clear, then load (first sample of a window), then increment.
   always_comb begin
      for (int c = 0; c < int'(NUM_CLASSES); c++) begin
         cnt_d[c] = cnt_q[c];
         if (clr_i)
            cnt_d[c] = '0;
         else if (ld_i)
            cnt_d[c] = CNT_W'(bits_i[c]);
         else if (inc_i)
            cnt_d[c] = cnt_q[c] + CNT_W'(bits_i[c]);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int c = 0; c < int'(NUM_CLASSES); c++) cnt_q[c] <= '0;
      end else begin
         for (int c = 0; c < int'(NUM_CLASSES); c++) cnt_q[c] <= cnt_d[c];
      end
   end

   assign rd_cnt_o = cnt_q[rd_idx_i];

   // At most one increment per sample, so a count can never exceed WINDOW.
   for (genvar c = 0; c < NUM_CLASSES; c++) begin : g_chk
      a_cnt_bound: assert property (@(posedge clk) disable iff (reset)
                                    cnt_q[c] <= CNT_W'(WINDOW));
   end

endmodule

// File: rtl/bnn_vote_accumulator.sv
// Counts per-class firings of the BNN output vector over a window of samples,
// then scans the counts one class per cycle to pick the argmax (lowest index
// wins ties) and holds the decision on a valid/ready handshake.
// Ports: clk, reset (async, active-high), clear (sync abort), in_valid/in_bits/
// in_ready (sample input), out_valid/out_ready/out_class/out_count/out_tie
// (decision output), dropped (sticky discarded-sample flag), busy.
module bnn_vote_accumulator
   import bnn_pkg::*;
#(
   parameter int unsigned NUM_CLASSES = bnn_pkg::NUM_CLASSES,
   parameter int unsigned WINDOW      = VOTE_WINDOW,
   parameter int unsigned CNT_W       = bnn_pkg::CNT_W,
   parameter int unsigned CLASS_W     = bnn_pkg::CLASS_W
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   clear,
   input  logic                   in_valid,
   input  logic [NUM_CLASSES-1:0] in_bits,
   output logic                   in_ready,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [CLASS_W-1:0]     out_class,
   output logic [CNT_W-1:0]       out_count,
   output logic                   out_tie,
   output logic                   dropped,
   output logic                   busy
);

   vote_state_t         state_q, state_d;
   logic [SAMPLE_W-1:0] sample_cnt_q, sample_cnt_d;
   logic [CLASS_W-1:0]  scan_idx_q, scan_idx_d;
   logic [CNT_W-1:0]    best_q, best_d;
   logic [CLASS_W-1:0]  arg_q, arg_d;
   logic                tie_q, tie_d;
   logic                out_valid_q, out_valid_d;
   logic [CLASS_W-1:0]  out_class_q, out_class_d;
   logic [CNT_W-1:0]    out_count_q, out_count_d;
   logic                out_tie_q, out_tie_d;
   logic                dropped_q, dropped_d;
   logic                in_ready_q, in_ready_d;
   logic                busy_q, busy_d;

   logic                accept;
   logic                cnt_clr, cnt_ld, cnt_inc;
   logic [CNT_W-1:0]    rd_cnt;

   bnn_vote_counter_bank #(
      .NUM_CLASSES (NUM_CLASSES),
      .CNT_W       (CNT_W),
      .CLASS_W     (CLASS_W),
      .WINDOW      (WINDOW)
   ) u_bank (
      .clk      (clk),
      .reset    (reset),
      .clr_i    (cnt_clr),
      .ld_i     (cnt_ld),
      .inc_i    (cnt_inc),
      .bits_i   (in_bits),
      .rd_idx_i (scan_idx_q),
      .rd_cnt_o (rd_cnt)
   );

   // Next-state and output logic.
   always_comb begin
      state_d      = state_q;
      sample_cnt_d = sample_cnt_q;
      scan_idx_d   = scan_idx_q;
      best_d       = best_q;
      arg_d        = arg_q;
      tie_d        = tie_q;
      out_valid_d  = out_valid_q;
      out_class_d  = out_class_q;
      out_count_d  = out_count_q;
      out_tie_d    = out_tie_q;
      dropped_d    = dropped_q;
      cnt_clr      = 1'b0;
      cnt_ld       = 1'b0;
      cnt_inc      = 1'b0;
      accept       = in_valid && in_ready_q;

      if (in_valid && !in_ready_q) dropped_d = 1'b1;

      case (state_q)
         IDLE: begin
            if (accept) begin
               cnt_ld       = 1'b1;
               sample_cnt_d = SAMPLE_W'(1);
               scan_idx_d   = '0;
               state_d      = (WINDOW == 1) ? SCAN : ACCUM;
            end
         end
         ACCUM: begin
            if (accept) begin
               cnt_inc      = 1'b1;
               sample_cnt_d = sample_cnt_q + SAMPLE_W'(1);
               if (sample_cnt_d == SAMPLE_W'(WINDOW)) begin
                  scan_idx_d = '0;
                  state_d    = SCAN;
               end
            end
         end
         SCAN: begin
            if (scan_idx_q == '0) begin
               best_d = rd_cnt;
               arg_d  = '0;
               tie_d  = 1'b0;
            end else if (rd_cnt > best_q) begin
               best_d = rd_cnt;
               arg_d  = scan_idx_q;
               tie_d  = 1'b0;
            end else if (rd_cnt == best_q) begin
               tie_d  = 1'b1;
            end
            if (scan_idx_q == CLASS_W'(NUM_CLASSES - 1)) begin
               out_valid_d = 1'b1;
               out_class_d = arg_d;
               out_count_d = best_d;
               out_tie_d   = tie_d;
               state_d     = HOLD;
            end else begin
               scan_idx_d  = scan_idx_q + CLASS_W'(1);
            end
         end
         HOLD: begin
            if (out_ready) begin
               out_valid_d  = 1'b0;
               cnt_clr      = 1'b1;
               sample_cnt_d = '0;
               state_d      = IDLE;
            end
         end
      endcase

      // Abort wins over everything above; a same-cycle sample is not counted.
      if (clear) begin
         state_d      = IDLE;
         cnt_clr      = 1'b1;
         cnt_ld       = 1'b0;
         cnt_inc      = 1'b0;
         sample_cnt_d = '0;
         scan_idx_d   = '0;
         out_valid_d  = 1'b0;
         out_class_d  = '0;
         out_count_d  = '0;
         out_tie_d    = 1'b0;
         dropped_d    = 1'b0;
      end

      // Registered status flags follow the state being entered.
      in_ready_d = (state_d == IDLE) || (state_d == ACCUM);
      busy_d     = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         sample_cnt_q <= '0;
         scan_idx_q   <= '0;
         best_q       <= '0;
         arg_q        <= '0;
         tie_q        <= 1'b0;
         out_valid_q  <= 1'b0;
         out_class_q  <= '0;
         out_count_q  <= '0;
         out_tie_q    <= 1'b0;
         dropped_q    <= 1'b0;
         in_ready_q   <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         sample_cnt_q <= sample_cnt_d;
         scan_idx_q   <= scan_idx_d;
         best_q       <= best_d;
         arg_q        <= arg_d;
         tie_q        <= tie_d;
         out_valid_q  <= out_valid_d;
         out_class_q  <= out_class_d;
         out_count_q  <= out_count_d;
         out_tie_q    <= out_tie_d;
         dropped_q    <= dropped_d;
         in_ready_q   <= in_ready_d;
         busy_q       <= busy_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_class = out_class_q;
   assign out_count = out_count_q;
   assign out_tie   = out_tie_q;
   assign dropped   = dropped_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_bnn_vote_accumulator.sv
// Directed bench for bnn_vote_accumulator with a window-level reference model
// compared against the DUT on every falling clock edge.
module tb_bnn_vote_accumulator;

   localparam int NC  = 4;
   localparam int WIN = 16;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       clear = 1'b0;
   logic       in_valid = 1'b0;
   logic [3:0] in_bits = 4'b0;
   logic       out_ready = 1'b0;
   logic       in_ready, out_valid, out_tie, dropped, busy;
   logic [1:0] out_class;
   logic [4:0] out_count;

   int n_checks = 0;
   int n_errors = 0;

   bnn_vote_accumulator dut (
      .clk       (clk),
      .reset     (reset),
      .clear     (clear),
      .in_valid  (in_valid),
      .in_bits   (in_bits),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_class (out_class),
      .out_count (out_count),
      .out_tie   (out_tie),
      .dropped   (dropped),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: phase 0 idle, 1 collecting, 2 scanning, 3 holding.
   int m_phase, m_n, m_scan;
   int m_cnt [NC];
   bit m_inready, m_busy, m_ovalid, m_tie, m_dropped;
   int m_class, m_count;

   task automatic m_reset();
      m_phase = 0; m_n = 0; m_scan = 0;
      for (int c = 0; c < NC; c++) m_cnt[c] = 0;
      m_inready = 0; m_busy = 0; m_ovalid = 0; m_tie = 0; m_dropped = 0;
      m_class = 0; m_count = 0;
   endtask

   task automatic m_decide();
      int best, arg;
      best = -1; arg = 0;
      for (int c = 0; c < NC; c++)
         if (m_cnt[c] > best) begin best = m_cnt[c]; arg = c; end
      m_tie = 0;
      for (int c = 0; c < NC; c++)
         if (c != arg && m_cnt[c] == best) m_tie = 1;
      m_class = arg; m_count = best;
   endtask

   task automatic m_step();
      bit acc;
      acc = in_valid && m_inready;
      if (in_valid && !m_inready) m_dropped = 1;
      if (clear) begin
         m_phase = 0; m_n = 0;
         for (int c = 0; c < NC; c++) m_cnt[c] = 0;
         m_ovalid = 0; m_class = 0; m_count = 0; m_tie = 0; m_dropped = 0;
      end else begin
         case (m_phase)
            0, 1: if (acc) begin
               for (int c = 0; c < NC; c++) m_cnt[c] += int'(in_bits[c]);
               m_n++;
               if (m_n == WIN) begin m_phase = 2; m_scan = 0; end
               else m_phase = 1;
            end
            2: begin
               m_scan++;
               if (m_scan == NC) begin m_decide(); m_ovalid = 1; m_phase = 3; end
            end
            default: if (out_ready) begin
               m_ovalid = 0; m_n = 0; m_phase = 0;
               for (int c = 0; c < NC; c++) m_cnt[c] = 0;
            end
         endcase
      end
      m_inready = (m_phase <= 1);
      m_busy    = (m_phase != 0);
   endtask

   initial begin
      m_reset();
      forever begin
         @(posedge clk or posedge reset);
         if (reset) m_reset();
         else m_step();
      end
   end

   // Continuous comparison against the model.
   initial begin
      forever begin
         @(negedge clk);
         if (!reset) begin
            chk("in_ready", int'(in_ready), int'(m_inready));
            chk("busy", int'(busy), int'(m_busy));
            chk("out_valid", int'(out_valid), int'(m_ovalid));
            chk("dropped", int'(dropped), int'(m_dropped));
            if (out_valid && m_ovalid) begin
               chk("out_class", int'(out_class), m_class);
               chk("out_count", int'(out_count), m_count);
               chk("out_tie", int'(out_tie), int'(m_tie));
            end
         end
      end
   end

   // Stimulus helpers: all called and returning on a falling edge.
   task automatic send(input logic [3:0] b, input int n, input int gap);
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b1; in_bits = b;
         @(negedge clk);
         in_valid = 1'b0;
         repeat (gap) @(negedge clk);
      end
   endtask

   task automatic wait_decision(input string name, input int lat, input int cls,
                                input int cnt, input int tie);
      int k;
      k = 0;
      while (!out_valid && k < 40) begin @(negedge clk); k++; end
      if (lat > 0) chk({name, "_latency"}, k, lat);
      chk({name, "_valid"}, int'(out_valid), 1);
      chk({name, "_class"}, int'(out_class), cls);
      chk({name, "_count"}, int'(out_count), cnt);
      chk({name, "_tie"}, int'(out_tie), tie);
      chk({name, "_model_class"}, m_class, cls);
      chk({name, "_model_count"}, m_count, cnt);
   endtask

   task automatic take();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("after_take_busy", int'(busy), 0);
      chk("after_take_in_ready", int'(in_ready), 1);
   endtask

   initial begin
      #1;
      chk("rst_in_ready", int'(in_ready), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_dropped", int'(dropped), 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", int'(in_ready), 1);

      // Single class fires every sample.
      send(4'b0100, 16, 0);
      wait_decision("w_c2", 4, 2, 16, 0);
      take();

      // Two classes tie; lowest index wins.
      send(4'b0011, 8, 0);
      send(4'b0000, 8, 0);
      wait_decision("w_tie", 4, 0, 8, 1);
      take();

      // Gapped input must not advance the window.
      send(4'b1000, 10, 1);
      send(4'b0110, 6, 1);
      wait_decision("w_gap", 0, 3, 10, 0);
      take();

      // Backpressure: outputs hold, samples dropped.
      send(4'b0101, 16, 0);
      wait_decision("w_bp", 4, 0, 16, 1);
      for (int i = 0; i < 20; i++) begin
         in_valid = 1'b1; in_bits = 4'($urandom_range(0, 15));
         @(negedge clk);
         chk("bp_class_stable", int'(out_class), 0);
         chk("bp_count_stable", int'(out_count), 16);
      end
      chk("bp_dropped", int'(dropped), 1);
      chk("bp_in_ready", int'(in_ready), 0);
      in_bits = 4'b1111;
      take();
      in_valid = 1'b0;
      send(4'b0010, 16, 0);
      wait_decision("w_after_bp", 4, 1, 16, 0);
      chk("after_bp_dropped_sticky", int'(dropped), 1);
      take();

      // Abort mid-window; the same-cycle sample is discarded.
      clear = 1'b1; @(negedge clk); clear = 1'b0;
      chk("clr_dropped", int'(dropped), 0);
      send(4'b1111, 7, 0);
      clear = 1'b1; in_valid = 1'b1; in_bits = 4'b1111;
      @(negedge clk);
      clear = 1'b0; in_valid = 1'b0;
      chk("clr_busy", int'(busy), 0);
      chk("clr_out_valid", int'(out_valid), 0);
      repeat (8) @(negedge clk);
      chk("clr_no_valid", int'(out_valid), 0);
      send(4'b0001, 16, 0);
      wait_decision("w_after_clr", 4, 0, 16, 0);
      chk("after_clr_dropped", int'(dropped), 0);
      take();

      // Asynchronous reset while scanning.
      send(4'b1000, 16, 0);
      @(negedge clk);
      chk("scan_busy", int'(busy), 1);
      #2 reset = 1'b1;
      #1;
      chk("arst_out_valid", int'(out_valid), 0);
      chk("arst_busy", int'(busy), 0);
      chk("arst_in_ready", int'(in_ready), 0);
      chk("arst_count", int'(out_count), 0);
      @(negedge clk);
      reset = 1'b0;
      repeat (10) @(negedge clk);
      chk("arst_no_valid", int'(out_valid), 0);
      send(4'b0010, 16, 0);
      wait_decision("w_after_rst", 4, 1, 16, 0);
      take();

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
